// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch widths, the bubble encoding and the IF/ID bundle
// that the fetch stage produces and the decode stage consumes.
package cpu_pkg;

    localparam int unsigned       PC_W      = 10;
    localparam int unsigned       INSTR_W   = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic               valid;
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } if_id_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register for a fetch response that arrives while decode is stalled.
// Priority: clear over load over drain.
module if_skid_buf
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   load_i,
    input  logic   drain_i,
    input  logic   clear_i,
    input  if_id_t data_i,
    output logic   valid_o,
    output if_id_t data_o
);

    logic   valid_q, valid_d;
    if_id_t data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) valid_q <= 1'b0;
        else       valid_q <= valid_d;
        // NOTE: the payload is deliberately left out of reset; valid_q alone decides whether it is used.
        data_q <= data_d;
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues imem reads, tracks the in-flight request, skids on
// decode stalls and flushes on taken branches. Define IF_STAGE_PERF_EN for perf counters.
module if_stage #(
    parameter int unsigned         PC_W      = cpu_pkg::PC_W,
    parameter int unsigned         INSTR_W   = cpu_pkg::INSTR_W,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc_in,
    input  logic               pc_branch,
    input  logic               id_stall,
    output logic               pc_hold,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_id_valid,
    output logic [PC_W-1:0]    if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr
`ifdef IF_STAGE_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);

    import cpu_pkg::if_id_t;

    logic            req_v_q;
    logic [PC_W-1:0] req_pc_q;
    if_id_t          if_id_q, if_id_d;
    if_id_t          rsp;
    if_id_t          skid_data;
    logic            skid_v;
    logic            skid_load, skid_drain;

    assign imem_addr = pc_in;
    assign imem_en   = !reset && !id_stall;
    assign pc_hold   = !reset && id_stall && !pc_branch;

    assign rsp = '{valid: 1'b1, pc: req_pc_q, instr: imem_rdata};

    // A bubble keeps the previous pc so the IF/ID pc never goes stale-to-zero mid-run.
    always_comb begin
        // NOTE: combinational blocks use blocking assignments with a full default first, so no latch forms.
        if_id_d    = if_id_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        if (pc_branch) begin
            if_id_d.valid = 1'b0;
            if_id_d.instr = NOP_INSTR;
        end else if (id_stall) begin
            skid_load = req_v_q;
        end else if (skid_v) begin
            if_id_d    = skid_data;
            skid_drain = 1'b1;
        end else if (req_v_q) begin
            if_id_d = rsp;
        end else begin
            if_id_d.valid = 1'b0;
            if_id_d.instr = NOP_INSTR;
        end
    end

    // A fetch issued alongside a taken branch is wrong-path and never becomes live.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments only.
        if (reset) begin
            req_v_q  <= 1'b0;
            req_pc_q <= '0;
            if_id_q  <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
        end else begin
            req_v_q  <= imem_en && !pc_branch;
            req_pc_q <= pc_in;
            if_id_q  <= if_id_d;
        end
    end

    if_skid_buf u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (pc_branch),
        .data_i  (rsp),
        .valid_o (skid_v),
        .data_o  (skid_data)
    );

    assign if_id_valid = if_id_q.valid;
    assign if_id_pc    = if_id_q.pc;
    assign if_id_instr = if_id_q.instr;

`ifdef IF_STAGE_PERF_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (!pc_branch && !id_stall && if_id_d.valid) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (id_stall)                                 stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
